// File: rtl/simon_pkg.sv
// Shared widths, rotation amounts, FSM state type and the Simon round function
// used by the iterative Feistel datapath.
package simon_pkg;

  localparam int WORD_W  = 32;
  localparam int BLOCK_W = 64;
  localparam int ROT_A   = 1;
  localparam int ROT_B   = 8;
  localparam int ROT_C   = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  // f(a) = (a<<<1 & a<<<8) ^ (a<<<2), rotations modulo the word width.
  function automatic logic [WORD_W-1:0] simon_f(input logic [WORD_W-1:0] a);
    logic [WORD_W-1:0] ra;
    logic [WORD_W-1:0] rb;
    logic [WORD_W-1:0] rc;
    ra = {a[WORD_W-1-ROT_A:0], a[WORD_W-1:WORD_W-ROT_A]};
    rb = {a[WORD_W-1-ROT_B:0], a[WORD_W-1:WORD_W-ROT_B]};
    rc = {a[WORD_W-1-ROT_C:0], a[WORD_W-1:WORD_W-ROT_C]};
    return (ra & rb) ^ rc;
  endfunction

endpackage

// File: rtl/simon_inv_round.sv
// One combinational inverse Feistel round: x = {y_lo, y_hi ^ f(y_lo) ^ k}.
module simon_inv_round
  import simon_pkg::*;
(
  input  logic [BLOCK_W-1:0] y,
  input  logic [WORD_W-1:0]  k,
  output logic [BLOCK_W-1:0] x
);

  logic [WORD_W-1:0] y_hi;
  logic [WORD_W-1:0] y_lo;

  assign y_hi = y[BLOCK_W-1:WORD_W];
  assign y_lo = y[WORD_W-1:0];
  assign x    = {y_lo, y_hi ^ simon_f(y_lo) ^ k};

endmodule

// File: rtl/simon_round.sv
// Forward Feistel round y = {x_lo ^ f(x_hi) ^ k, x_hi}; only built when
// SIMON_ENC_EN is defined, since the decrypt-only block has no use for it.
`ifdef SIMON_ENC_EN
module simon_round
  import simon_pkg::*;
(
  input  logic [BLOCK_W-1:0] x,
  input  logic [WORD_W-1:0]  k,
  output logic [BLOCK_W-1:0] y
);

  logic [WORD_W-1:0] x_hi;
  logic [WORD_W-1:0] x_lo;

  assign x_hi = x[BLOCK_W-1:WORD_W];
  assign x_lo = x[WORD_W-1:0];
  assign y    = {x_lo ^ simon_f(x_hi) ^ k, x_hi};

endmodule
`endif

// File: rtl/simon_dec_iter.sv
// Iterative Simon-style Feistel decryptor, one round per clock, keys read from
// a synchronous key store. SIMON_ENC_EN adds an `enc` port for forward rounds.
module simon_dec_iter
  import simon_pkg::*;
#(
  parameter int ROUNDS = 44,
  parameter int KEY_AW = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLOCK_W-1:0] in_data,
  output logic [KEY_AW-1:0]  key_addr,
  input  logic [WORD_W-1:0]  key_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] out_data,
  output logic               busy,
`ifdef SIMON_ENC_EN
  input  logic               enc,
`endif
  output state_e             dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid, once raised, holds with stable data until that edge.

  localparam logic [KEY_AW-1:0] LAST = KEY_AW'(ROUNDS - 1);

  state_e             state_q, state_d;
  logic [BLOCK_W-1:0] blk_q, blk_d;
  logic [KEY_AW-1:0]  key_addr_q, key_addr_d;
  logic [KEY_AW-1:0]  cnt_q, cnt_d;
  logic               out_valid_q, out_valid_d;
  logic               fwd_mode;
  logic               start_fwd;
  logic [KEY_AW-1:0]  key_step;
  logic [BLOCK_W-1:0] inv_out;
  logic [BLOCK_W-1:0] round_out;

  simon_inv_round u_inv_round (
    .y (blk_q),
    .k (key_data),
    .x (inv_out)
  );

`ifdef SIMON_ENC_EN
  logic               enc_q, enc_d;
  logic [BLOCK_W-1:0] fwd_out;

  simon_round u_fwd_round (
    .x (blk_q),
    .k (key_data),
    .y (fwd_out)
  );

  assign fwd_mode  = enc_q;
  assign start_fwd = enc;
  assign round_out = enc_q ? fwd_out : inv_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      enc_q <= 1'b0;
    end else begin
      enc_q <= enc_d;
    end
  end

  always_comb begin
    enc_d = enc_q;
    if (state_q == IDLE && in_valid) begin
      enc_d = enc;
    end
  end
`else
  assign fwd_mode  = 1'b0;
  assign start_fwd = 1'b0;
  assign round_out = inv_out;
`endif

  // Key address walks toward 0 (decrypt) or LAST (encrypt) and sticks there.
  always_comb begin
    key_step = key_addr_q;
    if (fwd_mode) begin
      if (key_addr_q != LAST) begin
        key_step = key_addr_q + 1'b1;
      end
    end else if (key_addr_q != '0) begin
      key_step = key_addr_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      blk_q       <= '0;
      key_addr_q  <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      blk_q       <= blk_d;
      key_addr_q  <= key_addr_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    blk_d       = blk_q;
    key_addr_d  = key_addr_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          blk_d      = in_data;
          cnt_d      = LAST;
          key_addr_d = start_fwd ? '0 : LAST;
          state_d    = LOAD;
        end
      end
      // Bubble: the key store is still returning data for the old address.
      LOAD: begin
        key_addr_d = key_step;
        state_d    = RUN;
      end
      RUN: begin
        blk_d      = round_out;
        key_addr_d = key_step;
        if (cnt_q == '0) begin
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign key_addr  = key_addr_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_valid_q ? blk_q : '0;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_simon_dec_iter.sv
// Bench for simon_dec_iter: a ROUNDS=1 and a ROUNDS=44 instance, each with its
// own synchronous key store, checked against a word-level Feistel model.
module tb_simon_dec_iter;
  import simon_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid;
  logic [63:0] in_data;
  logic        out_ready;
  logic        enc;
  bit          sel;  // 0 selects the ROUNDS=1 instance, 1 the ROUNDS=44 one

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] key_mem_a [0:63];
  logic [31:0] key_mem_b [0:63];

  logic        in_valid_a, in_ready_a, out_valid_a, out_ready_a, busy_a;
  logic [5:0]  key_addr_a;
  logic [31:0] key_data_a;
  logic [63:0] out_data_a;
  state_e      dbg_a;
  logic        in_valid_b, in_ready_b, out_valid_b, out_ready_b, busy_b;
  logic [5:0]  key_addr_b;
  logic [31:0] key_data_b;
  logic [63:0] out_data_b;
  state_e      dbg_b;

  assign in_valid_a  = in_valid & ~sel;
  assign in_valid_b  = in_valid & sel;
  assign out_ready_a = out_ready & ~sel;
  assign out_ready_b = out_ready & sel;

  always @(posedge clk) begin
    key_data_a <= key_mem_a[key_addr_a];
    key_data_b <= key_mem_b[key_addr_b];
  end

  simon_dec_iter #(.ROUNDS(1), .KEY_AW(6)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .in_data(in_data), .key_addr(key_addr_a), .key_data(key_data_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a), .out_data(out_data_a),
    .busy(busy_a),
`ifdef SIMON_ENC_EN
    .enc(enc),
`endif
    .dbg_state(dbg_a)
  );

  simon_dec_iter #(.ROUNDS(44), .KEY_AW(6)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_data(in_data), .key_addr(key_addr_b), .key_data(key_data_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
    .busy(busy_b),
`ifdef SIMON_ENC_EN
    .enc(enc),
`endif
    .dbg_state(dbg_b)
  );

  logic        o_in_ready, o_out_valid, o_busy;
  logic [5:0]  o_key_addr;
  logic [63:0] o_out_data;
  logic [1:0]  o_state;
  assign o_in_ready  = sel ? in_ready_b  : in_ready_a;
  assign o_out_valid = sel ? out_valid_b : out_valid_a;
  assign o_busy      = sel ? busy_b      : busy_a;
  assign o_key_addr  = sel ? key_addr_b  : key_addr_a;
  assign o_out_data  = sel ? out_data_b  : out_data_a;
  assign o_state     = sel ? dbg_b       : dbg_a;

  // ---------------- reference model ----------------
  function automatic logic [31:0] rol(input logic [31:0] a, input int n);
    return (a << n) | (a >> (32 - n));
  endfunction

  function automatic logic [31:0] ror(input logic [31:0] a, input int n);
    return (a >> n) | (a << (32 - n));
  endfunction

  function automatic logic [31:0] f_ref(input logic [31:0] a);
    return (rol(a, 1) & rol(a, 8)) ^ rol(a, 2);
  endfunction

  function automatic logic [31:0] key_of(input bit s, input int r);
    return s ? key_mem_b[6'(r)] : key_mem_a[6'(r)];
  endfunction

  function automatic logic [63:0] model_enc(input logic [63:0] p, input int rounds, input bit s);
    logic [31:0] hi, lo, t;
    hi = p[63:32];
    lo = p[31:0];
    for (int r = 0; r < rounds; r++) begin
      t  = lo ^ f_ref(hi) ^ key_of(s, r);
      lo = hi;
      hi = t;
    end
    return {hi, lo};
  endfunction

  function automatic logic [63:0] model_dec(input logic [63:0] c, input int rounds, input bit s);
    logic [31:0] hi, lo, t;
    hi = c[63:32];
    lo = c[31:0];
    for (int r = rounds - 1; r >= 0; r--) begin
      t  = hi ^ f_ref(lo) ^ key_of(s, r);
      hi = lo;
      lo = t;
    end
    return {hi, lo};
  endfunction

  // Simon64/128 key expansion (m=4, z3 sequence, LSB first).
  task automatic load_schedule();
    logic [31:0] k [0:43];
    logic [63:0] z;
    logic [31:0] tmp;
    z    = 64'hfc2ce51207a635db;
    k[0] = 32'h03020100;
    k[1] = 32'h0B0A0908;
    k[2] = 32'h13121110;
    k[3] = 32'h1B1A1918;
    for (int i = 4; i < 44; i++) begin
      tmp  = ror(k[i-1], 3) ^ k[i-3];
      tmp  = tmp ^ ror(tmp, 1);
      k[i] = ~k[i-4] ^ tmp ^ {31'b0, z[(i-4) % 62]} ^ 32'd3;
    end
    for (int i = 0; i < 44; i++) key_mem_b[i] = k[i];
  endtask

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [63:0] exp_q [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic check_idle(input string tag);
    bit saved;
    saved = sel;
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      #0;
      chk({tag, "_in_ready"},  64'(o_in_ready),  64'd1);
      chk({tag, "_out_valid"}, 64'(o_out_valid), 64'd0);
      chk({tag, "_out_data"},  o_out_data,       64'd0);
      chk({tag, "_key_addr"},  64'(o_key_addr),  64'd0);
      chk({tag, "_busy"},      64'(o_busy),      64'd0);
      chk({tag, "_state"},     64'(o_state),     64'(IDLE));
    end
    sel = saved;
    #0;
  endtask

  task automatic send(input logic [63:0] d, input logic e, output int unsigned acc);
    int n;
    n = 0;
    @(negedge clk);
    while (!o_in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("send_in_ready", 64'(o_in_ready), 64'd1);
    in_data  = d;
    enc      = e;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    acc      = cyc;
    in_valid = 1'b0;
    enc      = 1'b0;
  endtask

  // Waits for out_valid; optionally checks key_addr walk and busy each cycle.
  task automatic collect(input string tag, input int unsigned acc, input int rounds,
                         input bit chk_addr, input bit asc);
    int last;
    int ea;
    logic [63:0] exp;
    last = rounds - 1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (chk_addr) begin
        if (asc) ea = (k > last) ? last : k;
        else     ea = (k > last) ? 0 : last - k;
        chk({tag, "_key_addr"}, 64'(o_key_addr), 64'(ea));
        chk({tag, "_busy"},     64'(o_busy),     64'd1);
      end
      if (o_out_valid) break;
    end
    chk({tag, "_out_valid"}, 64'(o_out_valid), 64'd1);
    chk({tag, "_latency"},   64'(cyc - acc),   64'(rounds + 1));
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hx;
    chk({tag, "_out_data"}, o_out_data, exp);
  endtask

  task automatic release_out(input string tag, input int delay);
    repeat (delay) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_rel_out_valid"}, 64'(o_out_valid), 64'd0);
    chk({tag, "_rel_in_ready"},  64'(o_in_ready),  64'd1);
  endtask

  // ---------------- directed sequence ----------------
  logic [31:0] v_key [0:3];
  logic [63:0] v_in  [0:3];
  logic [63:0] v_out [0:3];

  initial begin
    int unsigned acc;
    logic [63:0] pt, ct, held;
    int seen;

    v_key = '{32'hFEDCBA98, 32'h8899AABB, 32'h76543210, 32'hF0E1D2C3};
    v_in  = '{64'h71BE60EB01234567, 64'hCCAA440000112233,
              64'h529DCB4089ABCDEF, 64'h910EB29FCAFEBABE};
    v_out = '{64'h0123456789ABCDEF, 64'h0011223344556677,
              64'h89ABCDEF01234567, 64'hCAFEBABEDEADBEEF};
    for (int i = 0; i < 64; i++) begin
      key_mem_a[i] = '0;
      key_mem_b[i] = '0;
    end
    sel = 1'b0; rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; enc = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    rst = 1'b0;

    // Single-round known answers
    sel = 1'b0;
    for (int i = 0; i < 4; i++) begin
      key_mem_a[0] = v_key[i];
      exp_q.push_back(v_out[i]);
      send(v_in[i], 1'b0, acc);
      collect($sformatf("r1_kat%0d", i), acc, 1, 1'b1, 1'b0);
      release_out($sformatf("r1_kat%0d", i), i);
    end

    // Single-round random
    for (int i = 0; i < 4; i++) begin
      key_mem_a[0] = $urandom;
      ct = {$urandom, $urandom};
      exp_q.push_back(model_dec(ct, 1, 1'b0));
      send(ct, 1'b0, acc);
      collect($sformatf("r1_rnd%0d", i), acc, 1, 1'b0, 1'b0);
      release_out($sformatf("r1_rnd%0d", i), $urandom_range(0, 3));
    end

    // Simon64/128 vector with key_addr walk, then backpressure in DONE
    sel = 1'b1;
    load_schedule();
    held = 64'h656B696C20646E75;
    exp_q.push_back(held);
    send(64'h44C8FC20B9DFA07A, 1'b0, acc);
    collect("r44_kat", acc, 44, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_out_valid", 64'(o_out_valid), 64'd1);
      chk("bp_out_data",  o_out_data,       held);
      chk("bp_in_ready",  64'(o_in_ready),  64'd0);
      in_valid = 1'($urandom_range(0, 1));
      in_data  = {$urandom, $urandom};
    end
    @(negedge clk);
    in_valid = 1'b0;
    release_out("bp", 0);
    chk("bp_busy_after", 64'(o_busy), 64'd0);
    @(negedge clk);
    chk("bp_no_accept", 64'(o_busy), 64'd0);

    // Random keys and plaintexts through the 44-round instance
    for (int i = 0; i < 3; i++) begin
      for (int r = 0; r < 44; r++) key_mem_b[r] = $urandom;
      pt = {$urandom, $urandom};
      ct = model_enc(pt, 44, 1'b1);
      exp_q.push_back(pt);
      send(ct, 1'b0, acc);
      collect($sformatf("r44_rnd%0d", i), acc, 44, 1'b0, 1'b0);
      release_out($sformatf("r44_rnd%0d", i), $urandom_range(0, 4));
    end

    // Reset during RUN round 20, then a fresh block
    load_schedule();
    send({$urandom, $urandom}, 1'b0, acc);
    repeat (21) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_idle("midrst");
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (o_out_valid) seen++;
    end
    chk("midrst_no_out_valid", 64'(seen), 64'd0);
    pt = {$urandom, $urandom};
    exp_q.push_back(pt);
    send(model_enc(pt, 44, 1'b1), 1'b0, acc);
    collect("post_rst", acc, 44, 1'b1, 1'b0);
    release_out("post_rst", 1);

`ifdef SIMON_ENC_EN
    exp_q.push_back(64'h44C8FC20B9DFA07A);
    send(64'h656B696C20646E75, 1'b1, acc);
    collect("enc_kat", acc, 44, 1'b1, 1'b1);
    release_out("enc_kat", 0);
    exp_q.push_back(64'h656B696C20646E75);
    send(64'h44C8FC20B9DFA07A, 1'b0, acc);
    collect("enc_back", acc, 44, 1'b1, 1'b0);
    release_out("enc_back", 0);
`endif

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
